// File: rtl/tdm_demux.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux
// Purpose  : Receive end of a TDM link. Collects NCH consecutive W-bit
//            samples (slot 0 marked by fsync) into a frame and presents all
//            lanes in parallel. Detects loss of frame alignment, flags it
//            and re-hunts for fsync.
// Ports    : clk        - rising-edge clock
//            rst_n      - asynchronous active-low reset
//            din        - serial TDM sample
//            din_valid  - din carries a sample this cycle (a "beat")
//            fsync      - beat carries slot 0
//            ch_data    - lane k = ch_data[k*W +: W], registered
//            ch_valid   - one-cycle pulse, ch_data holds a new frame
//            locked     - high while aligned (LOCK state)
//            frame_err  - one-cycle pulse on an alignment error
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux #(
  parameter int NCH = 4,
  parameter int W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     din,
  input  logic             din_valid,
  input  logic             fsync,
  output logic [NCH*W-1:0] ch_data,
  output logic             ch_valid,
  output logic             locked,
  output logic             frame_err
);

  localparam int CW = $clog2(NCH);
  localparam logic [CW-1:0] c_last_slot = CW'(NCH - 1);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           state_q,     state_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic [NCH*W-1:0] shadow_q,    shadow_d;
  logic [NCH*W-1:0] ch_data_q,   ch_data_d;
  logic             ch_valid_q,  ch_valid_d;
  logic             frame_err_q, frame_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      cnt_q       <= '0;
      shadow_q    <= '0;
      ch_data_q   <= '0;
      ch_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      ch_data_q   <= ch_data_d;
      ch_valid_q  <= ch_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    ch_data_d   = ch_data_q;
    ch_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    if (din_valid) begin
      case (state_q)
        HUNT: begin
          // Everything before the first fsync is discarded.
          if (fsync) begin
            shadow_d[W-1:0] = din;
            cnt_d           = CW'(1);
            state_d         = LOCK;
          end
        end

        LOCK: begin
          if (cnt_q == '0) begin
            if (fsync) begin
              shadow_d[W-1:0] = din;
              cnt_d           = CW'(1);
            end else begin
              // Expected slot 0 but no fsync: alignment lost.
              frame_err_d = 1'b1;
              cnt_d       = '0;
              state_d     = HUNT;
            end
          end else if (fsync) begin
            // Early sync: drop the partial frame and restart at slot 0.
            frame_err_d     = 1'b1;
            shadow_d[W-1:0] = din;
            cnt_d           = CW'(1);
          end else begin
            shadow_d[cnt_q*W +: W] = din;
            if (cnt_q == c_last_slot) begin
              // The last slot goes straight to the output so the frame is
              // published on the same edge that samples it.
              ch_data_d  = {din, shadow_q[(NCH-1)*W-1:0]};
              ch_valid_d = 1'b1;
              cnt_d      = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end

        default: begin
          state_d = HUNT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign ch_data   = ch_data_q;
  assign ch_valid  = ch_valid_q;
  assign locked    = (state_q == LOCK);
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_demux
// Purpose  : Directed self-checking bench for tdm_demux (NCH=4, W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_demux;

  localparam int NCH = 4;
  localparam int W   = 8;

  logic             clk;
  logic             rst_n;
  logic [W-1:0]     din;
  logic             din_valid;
  logic             fsync;
  logic [NCH*W-1:0] ch_data;
  logic             ch_valid;
  logic             locked;
  logic             frame_err;

  int checks = 0;
  int errors = 0;
  int vcnt   = 0;
  int ecnt   = 0;
  int v0, e0;

  tdm_demux #(.NCH(NCH), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .fsync     (fsync),
    .ch_data   (ch_data),
    .ch_valid  (ch_valid),
    .locked    (locked),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (ch_valid)  vcnt++;
    if (frame_err) ecnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input, then settle just after the rising edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic fs);
    @(negedge clk);
    din_valid = v;
    din       = d;
    fsync     = fs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; din = '0; din_valid = 1'b0; fsync = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    chk("rst_data",  ch_data,   32'h0);
    chk("rst_valid", ch_valid,  32'h0);
    chk("rst_lock",  locked,    32'h0);
    chk("rst_err",   frame_err, 32'h0);

    // Single frame, back to back.
    step(1, 8'hA0, 1);
    chk("a0_lock",  locked,   32'h1);
    chk("a0_valid", ch_valid, 32'h0);
    step(1, 8'hA1, 0);
    step(1, 8'hA2, 0);
    chk("a2_valid", ch_valid, 32'h0);
    step(1, 8'hA3, 0);
    chk("a3_valid", ch_valid, 32'h1);
    chk("a3_data",  ch_data,  32'hA3A2A1A0);
    step(0, 8'h00, 0);
    chk("a_pulse",  ch_valid, 32'h0);
    chk("a_hold",   ch_data,  32'hA3A2A1A0);

    // Two frames with a two-cycle gap between slots 1 and 2.
    v0 = vcnt; e0 = ecnt;
    step(1, 8'hB0, 1); step(1, 8'hB1, 0);
    step(0, 8'hFF, 1); step(0, 8'hFF, 0);
    step(1, 8'hB2, 0); step(1, 8'hB3, 0);
    chk("b_data", ch_data, 32'hB3B2B1B0);
    step(1, 8'hC0, 1); step(1, 8'hC1, 0);
    step(0, 8'hEE, 1); step(0, 8'hEE, 0);
    step(1, 8'hC2, 0); step(1, 8'hC3, 0);
    chk("c_valid", ch_valid, 32'h1);
    chk("c_data",  ch_data,  32'hC3C2C1C0);
    step(0, 8'h00, 0);
    chk("bc_pulses", vcnt - v0, 32'd2);
    chk("bc_errs",   ecnt - e0, 32'd0);

    // Early sync.
    v0 = vcnt;
    step(1, 8'h10, 1); step(1, 8'h11, 0);
    step(1, 8'h20, 1);
    chk("es_err",   frame_err, 32'h1);
    chk("es_lock",  locked,    32'h1);
    chk("es_data",  ch_data,   32'hC3C2C1C0);
    step(1, 8'h21, 0);
    chk("es_err1",  frame_err, 32'h0);
    step(1, 8'h22, 0); step(1, 8'h23, 0);
    chk("es_valid", ch_valid,  32'h1);
    chk("es_data2", ch_data,   32'h23222120);
    step(0, 8'h00, 0);
    chk("es_pulses", vcnt - v0, 32'd1);

    // Missing sync after a full frame.
    step(1, 8'h30, 1); step(1, 8'h31, 0); step(1, 8'h32, 0); step(1, 8'h33, 0);
    chk("ms_frame", ch_data, 32'h33323130);
    step(1, 8'h55, 0);
    chk("ms_err",   frame_err, 32'h1);
    chk("ms_lock",  locked,    32'h0);
    chk("ms_valid", ch_valid,  32'h0);
    step(1, 8'h56, 0);
    chk("ms_err1",  frame_err, 32'h0);
    chk("ms_hunt",  locked,    32'h0);
    chk("ms_hold",  ch_data,   32'h33323130);
    step(1, 8'h40, 1);
    chk("rl_lock",  locked,    32'h1);
    step(1, 8'h41, 0); step(1, 8'h42, 0); step(1, 8'h43, 0);
    chk("rl_valid", ch_valid,  32'h1);
    chk("rl_data",  ch_data,   32'h43424140);

    // Reset mid-frame takes effect without a clock edge.
    step(1, 8'h50, 1); step(1, 8'h51, 0);
    @(negedge clk);
    din_valid = 1'b0; fsync = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mr_data", ch_data,  32'h0);
    chk("mr_lock", locked,   32'h0);
    chk("mr_valid", ch_valid, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    // Slots 2/3 of the lost frame must not complete anything.
    step(1, 8'h52, 0); step(1, 8'h53, 0);
    chk("mr_nolock", locked,   32'h0);
    chk("mr_novalid", ch_valid, 32'h0);
    step(1, 8'h60, 1); step(1, 8'h61, 0); step(1, 8'h62, 0); step(1, 8'h63, 0);
    chk("pr_valid", ch_valid, 32'h1);
    chk("pr_data",  ch_data,  32'h63626160);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
